// File: rtl/controller_poller_pkg.sv
// Shared types and poll-timing helpers for the controller poller.
package controller_poller_pkg;

    // Poll sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StShiftLo,
        StShiftHi,
        StDone
    } poll_state_e;

    localparam int unsigned DEF_NUM_CONTROLLERS = 2;
    localparam int unsigned DEF_NUM_BUTTONS     = 8;
    localparam int unsigned DEF_CLK_DIV         = 1;
    localparam int unsigned DEF_AUTO_PERIOD     = 1024;

    // Cycles from the edge that accepts a trigger to the cycle where valid is high.
    function automatic int unsigned poll_latency(input int unsigned clk_div,
                                                 input int unsigned num_buttons);
        return 2 * clk_div * (num_buttons + 1) + 1;
    endfunction

    // Start-to-start spacing when start is held high.
    function automatic int unsigned poll_period(input int unsigned clk_div,
                                                input int unsigned num_buttons);
        return poll_latency(clk_div, num_buttons) + 1;
    endfunction

    localparam int unsigned DEF_POLL_LATENCY = poll_latency(DEF_CLK_DIV, DEF_NUM_BUTTONS);
    localparam int unsigned DEF_POLL_PERIOD  = poll_period(DEF_CLK_DIV, DEF_NUM_BUTTONS);

endpackage

// File: rtl/controller_poller_if.sv
// CPU-side request/result signals and pad-side serial signals of the poller.
interface controller_poller_if #(
    parameter int unsigned NUM_CONTROLLERS = 2,
    parameter int unsigned NUM_BUTTONS     = 8
);
    localparam int unsigned W = NUM_CONTROLLERS * NUM_BUTTONS;

    logic                       start;
    logic                       auto_en;
    logic                       controller_clk;
    logic                       controller_latch;
    logic [NUM_CONTROLLERS-1:0] controller_data_B;
    logic [W-1:0]               buttons_out;
    logic [W-1:0]               pressed_out;
    logic [W-1:0]               released_out;
    logic                       busy;
    logic                       valid;

    // Environment side: CPU registers and pad connectors.
    modport master (
        output start, auto_en, controller_data_B,
        input  controller_clk, controller_latch, buttons_out, pressed_out, released_out,
        input  busy, valid
    );

    // Poller side.
    modport slave (
        input  start, auto_en, controller_data_B,
        output controller_clk, controller_latch, buttons_out, pressed_out, released_out,
        output busy, valid
    );

endinterface

// File: rtl/controller_poller_channel.sv
// One pad: serial capture register, published button word and edge flags.
module controller_poller_channel
    import controller_poller_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS = 8,
    parameter int unsigned IDX_W       = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_sample_en,
    input  logic [IDX_W-1:0]       i_bit_idx,
    input  logic                   i_data_b,
    input  logic                   i_publish_en,
    output logic [NUM_BUTTONS-1:0] o_buttons,
    output logic [NUM_BUTTONS-1:0] o_pressed,
    output logic [NUM_BUTTONS-1:0] o_released
);

    logic [NUM_BUTTONS-1:0] r_shift;
    logic [NUM_BUTTONS-1:0] r_buttons;
    logic [NUM_BUTTONS-1:0] r_pressed;
    logic [NUM_BUTTONS-1:0] r_released;

    // Capture the inverted serial bit into the slot selected by the bit index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
        end else if (i_sample_en) begin
            for (int unsigned b = 0; b < NUM_BUTTONS; b++) begin
                if (i_bit_idx == IDX_W'(b)) begin
                    r_shift[b] <= ~i_data_b;
                end
            end
        end
    end

    // Publish the completed word and compute edges against the previous word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buttons  <= '0;
            r_pressed  <= '0;
            r_released <= '0;
        end else if (i_publish_en) begin
            r_buttons  <= r_shift;
            r_pressed  <= r_shift & ~r_buttons;
            r_released <= ~r_shift & r_buttons;
        end
    end

    assign o_buttons  = r_buttons;
    assign o_pressed  = r_pressed;
    assign o_released = r_released;

endmodule

// File: rtl/controller_poller.sv
// Polls NUM_CONTROLLERS serial pads in parallel over a shared clock/latch pair.
module controller_poller
    import controller_poller_pkg::*;
#(
    parameter int unsigned NUM_CONTROLLERS = DEF_NUM_CONTROLLERS,
    parameter int unsigned NUM_BUTTONS     = DEF_NUM_BUTTONS,
    parameter int unsigned CLK_DIV         = DEF_CLK_DIV,
    parameter int unsigned AUTO_PERIOD     = DEF_AUTO_PERIOD
) (
    input  logic                 clk_1,
    input  logic                 rst_B,
    controller_poller_if.slave   bus
);

    localparam int unsigned IDX_W = $clog2(NUM_BUTTONS + 1);
    localparam int unsigned DIV_W = $clog2(2 * CLK_DIV + 1);
    localparam int unsigned TMR_W = $clog2(AUTO_PERIOD);
    localparam int unsigned W     = NUM_CONTROLLERS * NUM_BUTTONS;

    localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] SHIFT_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] BIT_LAST   = IDX_W'(NUM_BUTTONS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(AUTO_PERIOD - 1);

    poll_state_e      r_state;
    poll_state_e      w_state_next;
    logic [DIV_W-1:0] r_div;
    logic [IDX_W-1:0] r_bit;
    logic [TMR_W-1:0] r_tmr;

    logic             w_auto_tick;
    logic             w_phase_end;
    logic             w_last_bit;
    logic             w_div_run;
    logic             w_sample_en;
    logic             w_publish_en;
    logic [W-1:0]     w_buttons;
    logic [W-1:0]     w_pressed;
    logic [W-1:0]     w_released;

    assign w_auto_tick = bus.auto_en && (r_tmr == TMR_LAST);
    assign w_last_bit  = (r_bit == BIT_LAST);

    // Free-running auto-poll timer; runs regardless of busy, cleared while disabled.
    always_ff @(posedge clk_1 or negedge rst_B) begin
        if (!rst_B) begin
            r_tmr <= '0;
        end else if (!bus.auto_en || (r_tmr == TMR_LAST)) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    // Phase length depends on state: latch is held twice as long as a clock half-period.
    always_comb begin
        w_phase_end = 1'b0;
        unique case (r_state)
            StLatch:              w_phase_end = (r_div == LATCH_LAST);
            StShiftLo, StShiftHi: w_phase_end = (r_div == SHIFT_LAST);
            default:              w_phase_end = 1'b0;
        endcase
    end

    assign w_div_run = ((r_state == StLatch) || (r_state == StShiftLo) ||
                        (r_state == StShiftHi)) && !w_phase_end;

    // Divider restarts at every phase boundary and idles at zero.
    always_ff @(posedge clk_1 or negedge rst_B) begin
        if (!rst_B) begin
            r_div <= '0;
        end else if (w_div_run) begin
            r_div <= r_div + 1'b1;
        end else begin
            r_div <= '0;
        end
    end

    // Bit index: cleared during latch, advanced at the end of each clock-high phase.
    always_ff @(posedge clk_1 or negedge rst_B) begin
        if (!rst_B) begin
            r_bit <= '0;
        end else if (r_state == StLatch) begin
            r_bit <= '0;
        end else if ((r_state == StShiftHi) && w_phase_end && !w_last_bit) begin
            r_bit <= r_bit + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk_1 or negedge rst_B) begin
        if (!rst_B) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; triggers outside IDLE are simply not looked at.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (bus.start || w_auto_tick) w_state_next = StLatch;
            StLatch:   if (w_phase_end) w_state_next = StShiftLo;
            StShiftLo: if (w_phase_end) w_state_next = StShiftHi;
            StShiftHi: if (w_phase_end) w_state_next = w_last_bit ? StDone : StShiftLo;
            StDone:    w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    // Outputs decode the state register only, so reset forces them low immediately.
    always_comb begin
        bus.controller_latch = (r_state == StLatch);
        bus.controller_clk   = (r_state == StShiftHi);
        bus.busy             = (r_state != StIdle);
        bus.valid            = (r_state == StDone);
        w_sample_en          = (r_state == StShiftLo) && w_phase_end;
        // Publish on entry to DONE so valid coincides with the new words.
        w_publish_en         = (r_state == StShiftHi) && w_phase_end && w_last_bit;
    end

    for (genvar c = 0; c < NUM_CONTROLLERS; c++) begin : g_chan
        controller_poller_channel #(
            .NUM_BUTTONS (NUM_BUTTONS),
            .IDX_W       (IDX_W)
        ) u_chan (
            .i_clk        (clk_1),
            .i_rst_n      (rst_B),
            .i_sample_en  (w_sample_en),
            .i_bit_idx    (r_bit),
            .i_data_b     (bus.controller_data_B[c]),
            .i_publish_en (w_publish_en),
            .o_buttons    (w_buttons[c*NUM_BUTTONS +: NUM_BUTTONS]),
            .o_pressed    (w_pressed[c*NUM_BUTTONS +: NUM_BUTTONS]),
            .o_released   (w_released[c*NUM_BUTTONS +: NUM_BUTTONS])
        );
    end

    assign bus.buttons_out  = w_buttons;
    assign bus.pressed_out  = w_pressed;
    assign bus.released_out = w_released;

endmodule

// File: tb/tb_controller_poller.sv
// Directed bench for controller_poller with pad models and an expected-result queue.
module tb_controller_poller;

    logic clk_1 = 1'b0;
    always #5 clk_1 = ~clk_1;

    logic rst_a;
    logic rst_bc;
    int   vectors     = 0;
    int   miscompares = 0;

    controller_poller_if #(.NUM_CONTROLLERS(2), .NUM_BUTTONS(8))  ifa ();
    controller_poller_if #(.NUM_CONTROLLERS(4), .NUM_BUTTONS(12)) ifb ();
    controller_poller_if #(.NUM_CONTROLLERS(2), .NUM_BUTTONS(8))  ifc ();

    controller_poller #(
        .NUM_CONTROLLERS (2), .NUM_BUTTONS (8), .CLK_DIV (1), .AUTO_PERIOD (1024)
    ) dut_a (.clk_1 (clk_1), .rst_B (rst_a), .bus (ifa));

    controller_poller #(
        .NUM_CONTROLLERS (4), .NUM_BUTTONS (12), .CLK_DIV (3), .AUTO_PERIOD (1024)
    ) dut_b (.clk_1 (clk_1), .rst_B (rst_bc), .bus (ifb));

    controller_poller #(
        .NUM_CONTROLLERS (2), .NUM_BUTTONS (8), .CLK_DIV (1), .AUTO_PERIOD (40)
    ) dut_c (.clk_1 (clk_1), .rst_B (rst_bc), .bus (ifc));

    // Pad models: parallel load while latch is high, shift on each controller_clk rise.
    logic [15:0] pa_val = '0, pa_sr = '0;
    logic [47:0] pb_val = '0, pb_sr = '0;
    logic        pa_clk_q = 1'b0, pb_clk_q = 1'b0;

    always @(posedge clk_1) begin
        pa_clk_q <= ifa.controller_clk;
        if (ifa.controller_latch) pa_sr <= pa_val;
        else if (ifa.controller_clk && !pa_clk_q)
            for (int c = 0; c < 2; c++) pa_sr[c*8 +: 8] <= pa_sr[c*8 +: 8] >> 1;
    end

    always @(posedge clk_1) begin
        pb_clk_q <= ifb.controller_clk;
        if (ifb.controller_latch) pb_sr <= pb_val;
        else if (ifb.controller_clk && !pb_clk_q)
            for (int c = 0; c < 4; c++) pb_sr[c*12 +: 12] <= pb_sr[c*12 +: 12] >> 1;
    end

    assign ifa.controller_data_B = {~pa_sr[8], ~pa_sr[0]};
    assign ifb.controller_data_B = {~pb_sr[36], ~pb_sr[24], ~pb_sr[12], ~pb_sr[0]};
    assign ifc.controller_data_B = 2'b10;  // pad0 all buttons down, pad1 none

    // Cumulative pad-pin activity, sampled away from the active edge.
    int   a_lat = 0, a_chi = 0, a_rise = 0, b_lat = 0, b_chi = 0, b_rise = 0;
    logic a_cprev = 1'b0, b_cprev = 1'b0;
    always @(negedge clk_1) begin
        if (ifa.controller_latch) a_lat++;
        if (ifa.controller_clk) a_chi++;
        if (ifa.controller_clk && !a_cprev) a_rise++;
        a_cprev = ifa.controller_clk;
        if (ifb.controller_latch) b_lat++;
        if (ifb.controller_clk) b_chi++;
        if (ifb.controller_clk && !b_cprev) b_rise++;
        b_cprev = ifb.controller_clk;
    end

    typedef struct {
        string       tag;
        logic [47:0] btn;
        logic [47:0] prs;
        logic [47:0] rel;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [47:0] prev_a = '0, prev_b = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_valid(input int sel);
        return (sel == 0) ? ifa.valid : ifb.valid;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) ifa.start = v;
        else          ifb.start = v;
    endtask

    task automatic push_exp(input string tag, input int sel, input int lat);
        exp_t        e;
        logic [47:0] nw, old;
        if (sel == 0) begin
            nw = {32'h0, pa_val}; old = prev_a; prev_a = nw;
        end else begin
            nw = pb_val; old = prev_b; prev_b = nw;
        end
        e.tag = tag;
        e.btn = nw;
        e.prs = nw & ~old;
        e.rel = ~nw & old;
        e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic compare_pop(input int sel, input int lat_obs);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_underflow: observed unexpected valid expected none");
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_latency"}, 64'(lat_obs), 64'(e.lat));
        if (sel == 0) begin
            check({e.tag, "_buttons"},  {48'h0, ifa.buttons_out},  {16'h0, e.btn});
            check({e.tag, "_pressed"},  {48'h0, ifa.pressed_out},  {16'h0, e.prs});
            check({e.tag, "_released"}, {48'h0, ifa.released_out}, {16'h0, e.rel});
        end else begin
            check({e.tag, "_buttons"},  {16'h0, ifb.buttons_out},  {16'h0, e.btn});
            check({e.tag, "_pressed"},  {16'h0, ifb.pressed_out},  {16'h0, e.prs});
            check({e.tag, "_released"}, {16'h0, ifb.released_out}, {16'h0, e.rel});
        end
    endtask

    // One start pulse, bounded wait for valid, then scoreboard and pin-activity checks.
    task automatic run_poll(input int sel, input string tag, input int lat,
                            input int latw, input int chi, input int rise);
        int n, l0, c0, r0;
        repeat (3) @(negedge clk_1);
        push_exp(tag, sel, lat);
        l0 = (sel == 0) ? a_lat : b_lat;
        c0 = (sel == 0) ? a_chi : b_chi;
        r0 = (sel == 0) ? a_rise : b_rise;
        set_start(sel, 1'b1);
        @(negedge clk_1);
        set_start(sel, 1'b0);
        n = 1;
        while (!get_valid(sel) && n < 300) begin
            @(negedge clk_1);
            n++;
        end
        compare_pop(sel, n);
        check({tag, "_latch_cycles"}, 64'(((sel == 0) ? a_lat : b_lat) - l0), 64'(latw));
        check({tag, "_clk_high"},     64'(((sel == 0) ? a_chi : b_chi) - c0), 64'(chi));
        check({tag, "_clk_rises"},    64'(((sel == 0) ? a_rise : b_rise) - r0), 64'(rise));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nv;
        ifa.start = 0; ifa.auto_en = 0;
        ifb.start = 0; ifb.auto_en = 0;
        ifc.start = 0; ifc.auto_en = 0;
        rst_a = 0; rst_bc = 0;
        repeat (3) @(negedge clk_1);

        // Reset state.
        check("rst_a_buttons", {48'h0, ifa.buttons_out}, 64'h0);
        check("rst_a_pressed", {48'h0, ifa.pressed_out}, 64'h0);
        check("rst_a_pins", {62'h0, ifa.controller_clk, ifa.controller_latch}, 64'h0);
        check("rst_a_busy_valid", {62'h0, ifa.busy, ifa.valid}, 64'h0);
        check("rst_b_buttons", {16'h0, ifb.buttons_out}, 64'h0);
        rst_a = 1; rst_bc = 1;

        // 1: basic poll, first result is all presses.
        pa_val = 16'h7FFE;
        run_poll(0, "t1", 19, 2, 8, 8);

        // 2: one button released on pad0.
        pa_val = 16'h7FFC;
        run_poll(0, "t2", 19, 2, 8, 8);

        // 3: start held high for 60 cycles gives back-to-back polls every 20 cycles.
        repeat (3) @(negedge clk_1);
        push_exp("t3a", 0, 19);
        push_exp("t3b", 0, 39);
        push_exp("t3c", 0, 59);
        nv = 0;
        ifa.start = 1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk_1);
            if (ifa.valid) begin
                nv++;
                compare_pop(0, i);
            end
        end
        ifa.start = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_1);
            if (ifa.valid) nv++;
        end
        check("t3_valid_count", 64'(nv), 64'd3);
        check("t3_idle_after", {63'h0, ifa.busy}, 64'h0);

        // 4: wide configuration.
        pb_val = {12'h001, 12'h800, 12'h3F1, 12'hA5C};
        run_poll(1, "t4", 79, 6, 36, 12);
        pb_val = {12'h003, 12'h000, 12'hFF1, 12'hA5D};
        run_poll(1, "t4b", 79, 6, 36, 12);

        // 5: auto-poll every 40 cycles; coincident start gives a single poll.
        @(negedge clk_1);
        ifc.auto_en = 1;
        n = 0;
        do begin @(negedge clk_1); n++; end while (!ifc.valid && n < 200);
        check("t5_first_tick_valid", 64'(n), 64'd58);
        check("t5_first_buttons", {48'h0, ifc.buttons_out}, 64'h00FF);
        check("t5_first_pressed", {48'h0, ifc.pressed_out}, 64'h00FF);
        n = 0;
        do begin @(negedge clk_1); n++; end while (!ifc.valid && n < 200);
        check("t5_period", 64'(n), 64'd40);
        check("t5_second_pressed", {48'h0, ifc.pressed_out}, 64'h0);
        check("t5_second_released", {48'h0, ifc.released_out}, 64'h0);
        repeat (21) @(negedge clk_1);
        ifc.start = 1;
        @(negedge clk_1);
        ifc.start = 0;
        n = 1;
        while (!ifc.valid && n < 200) begin @(negedge clk_1); n++; end
        check("t5_coincident_latency", 64'(n), 64'd19);
        n = 0;
        do begin @(negedge clk_1); n++; end while (!ifc.valid && n < 200);
        check("t5_next_after_coincident", 64'(n), 64'd40);
        ifc.auto_en = 0;
        nv = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_1);
            if (ifc.valid) nv++;
        end
        check("t5_disabled_no_polls", 64'(nv), 64'd0);

        // 6: asynchronous reset mid-poll.
        repeat (3) @(negedge clk_1);
        pa_val = 16'h1234;
        ifa.start = 1;
        @(negedge clk_1);
        ifa.start = 0;
        repeat (6) @(negedge clk_1);
        check("t6_busy_before", {63'h0, ifa.busy}, 64'h1);
        @(posedge clk_1);
        #1;
        check("t6_clk_high_before", {63'h0, ifa.controller_clk}, 64'h1);
        rst_a = 0;
        #1;
        check("t6_pins_dropped",
              {60'h0, ifa.controller_clk, ifa.controller_latch, ifa.busy, ifa.valid}, 64'h0);
        check("t6_buttons_cleared", {48'h0, ifa.buttons_out}, 64'h0);
        check("t6_pressed_cleared", {48'h0, ifa.pressed_out}, 64'h0);
        prev_a = '0;
        @(negedge clk_1);
        rst_a = 1;
        run_poll(0, "t6_fresh", 19, 2, 8, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
